// File: rtl/mat_addr_seq_pkg.sv
// mat_addr_seq_pkg: shared state encoding, default widths and walk-order constants.
package mat_addr_seq_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
    localparam int ADDR_W_DEF = 16;
    localparam int DIM_W_DEF = 8;
    localparam logic ROW_MAJOR = 1'b0;
    localparam logic COL_MAJOR = 1'b1;
endpackage

// File: rtl/addr_stride_acc.sv
// addr_stride_acc: address register with load, inner-step add and outer-step add; load wins.
module addr_stride_acc #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         inner_en,
    input  logic [W-1:0] inner_step,
    input  logic         outer_en,
    input  logic [W-1:0] outer_step,
    output logic [W-1:0] q
);
    logic [W-1:0] nxt;

    always_comb
        nxt = load ? load_val : outer_en ? q + outer_step : inner_en ? q + inner_step : q;

    always_ff @(posedge clk)
        q <= reset ? '0 : nxt;
endmodule

// File: rtl/mat_addr_seq.sv
// mat_addr_seq: walks an R x C tile with row stride k in row- or column-major order over valid/ready.
module mat_addr_seq
    import mat_addr_seq_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DIM_W  = DIM_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] k,
    input  logic [DIM_W-1:0]  n_rows,
    input  logic [DIM_W-1:0]  n_cols,
    input  logic              col_major,
    output logic [ADDR_W-1:0] addr_out,
    output logic              addr_valid,
    input  logic              addr_ready,
    output logic              last,
    output logic              busy,
    output logic              done
);
    state_t state, state_nxt;
    logic [ADDR_W-1:0] k_r, addr_q, line_q, inner_step, outer_step, line_nxt;
    logic [DIM_W-1:0] rows_r, cols_r, inner, outer, inner_lim, outer_lim;
    logic cm_r, start_go, xfer, eol, last_i;

    assign start_go   = state == IDLE && start;
    assign xfer       = state == RUN && addr_ready;
    assign inner_lim  = cm_r == COL_MAJOR ? rows_r : cols_r;
    assign outer_lim  = cm_r == COL_MAJOR ? cols_r : rows_r;
    assign inner_step = cm_r == COL_MAJOR ? k_r : ADDR_W'(1);
    assign outer_step = cm_r == COL_MAJOR ? ADDR_W'(1) : k_r;
    assign eol        = inner == inner_lim - DIM_W'(1);
    assign last_i     = eol && outer == outer_lim - DIM_W'(1);
    assign line_nxt   = line_q + outer_step;

    // line_base advances per line; addr jumps to the new line_base at end of line
    addr_stride_acc #(.W(ADDR_W)) u_line (
        .clk(clk), .reset(reset),
        .load(start_go), .load_val(base_addr),
        .inner_en(1'b0), .inner_step(inner_step),
        .outer_en(xfer && eol), .outer_step(outer_step),
        .q(line_q)
    );

    addr_stride_acc #(.W(ADDR_W)) u_addr (
        .clk(clk), .reset(reset),
        .load(start_go || (xfer && eol)), .load_val(start_go ? base_addr : line_nxt),
        .inner_en(xfer), .inner_step(inner_step),
        .outer_en(1'b0), .outer_step(outer_step),
        .q(addr_q)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            inner  <= '0;
            outer  <= '0;
            k_r    <= '0;
            rows_r <= '0;
            cols_r <= '0;
            cm_r   <= ROW_MAJOR;
        end else begin
            state <= state_nxt;
            if (start_go) begin
                k_r    <= k;
                rows_r <= n_rows;
                cols_r <= n_cols;
                cm_r   <= col_major;
                inner  <= '0;
                outer  <= '0;
            end else if (xfer) begin
                inner <= eol ? '0 : inner + DIM_W'(1);
                outer <= eol ? outer + DIM_W'(1) : outer;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = (n_rows == '0 || n_cols == '0) ? DONE : RUN;
            RUN:  if (xfer && last_i) state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign addr_valid = state == RUN;
    assign busy       = state == RUN;
    assign done       = state == DONE;
    assign last       = state == RUN && last_i;
    assign addr_out   = state == RUN ? addr_q : '0;
endmodule
